// File: rtl/ibex_hpm_counter_bank_pkg.sv
// ----------------------------------------------------------------------------
// ibex_hpm_counter_bank_pkg
// Shared constants and helpers for the hardware performance monitor bank.
//   - CSR base addresses of the mhpmevent, mhpmcounter and mhpmcounterh pages.
//   - MHPM_MAX_COUNTERS: architectural number of HPM indices (3..31).
//   - hpm_space_e / hpm_space(): classify a CSR number into the 32-entry page
//     it falls in. Indices 0..2 are filtered out by the caller.
// ----------------------------------------------------------------------------
package ibex_hpm_counter_bank_pkg;

  localparam logic [11:0] CSR_OFF_MHPMEVENT    = 12'h320;
  localparam logic [11:0] CSR_OFF_MHPMCOUNTER  = 12'hB00;
  localparam logic [11:0] CSR_OFF_MHPMCOUNTERH = 12'hB80;

  // mcountinhibit shares the page of the event selectors (index 0).
  localparam logic [11:0] CSR_MCOUNTINHIBIT    = CSR_OFF_MHPMEVENT;

  localparam int unsigned MHPM_MAX_COUNTERS = 29;
  localparam int unsigned MHPM_FIRST_IDX    = 3;

  typedef enum logic [1:0] {
    HPM_SPACE_NONE,
    HPM_SPACE_EVENT,
    HPM_SPACE_CNT_LO,
    HPM_SPACE_CNT_HI
  } hpm_space_e;

  // Each page is 32 CSRs wide and aligned, so the page is addr[11:5].
  function automatic hpm_space_e hpm_space(input logic [11:0] addr);
    hpm_space_e space;
    space = HPM_SPACE_NONE;
    if (addr[11:5] == CSR_OFF_MHPMEVENT[11:5]) begin
      space = HPM_SPACE_EVENT;
    end else if (addr[11:5] == CSR_OFF_MHPMCOUNTER[11:5]) begin
      space = HPM_SPACE_CNT_LO;
    end else if (addr[11:5] == CSR_OFF_MHPMCOUNTERH[11:5]) begin
      space = HPM_SPACE_CNT_HI;
    end
    return space;
  endfunction

endpackage

// File: rtl/ibex_hpm_counter_bank_counter.sv
// ----------------------------------------------------------------------------
// ibex_hpm_counter
// One performance counter of configurable width with split 32-bit CSR writes.
// Ports:
//   clk_i, rst_ni   clock, asynchronous active-low reset
//   inc_i           count one this cycle
//   we_lo_i         write counter[31:0] from wdata_i
//   we_hi_i         write counter[W-1:32] from wdata_i[W-33:0] (ignored if W==32)
//   wdata_i         CSR write data
//   value_o         current counter value
//   ovf_o           registered one-cycle pulse when the counter wraps to 0
// A write always takes priority over an increment in the same cycle; the
// unwritten half is held and no overflow is reported.
// ----------------------------------------------------------------------------
module ibex_hpm_counter #(
  parameter int unsigned CounterWidth = 40
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic                    inc_i,
  input  logic                    we_lo_i,
  input  logic                    we_hi_i,
  input  logic [31:0]             wdata_i,
  output logic [CounterWidth-1:0] value_o,
  output logic                    ovf_o
);

  logic [CounterWidth-1:0] cnt_q, cnt_d;
  logic [CounterWidth-1:0] cnt_lo_wr, cnt_hi_wr;
  logic [CounterWidth:0]   cnt_inc;
  logic                    hi_en;
  logic                    ovf_q, ovf_d;

  // Merged values for each half-write; built per width so the upper slice
  // only exists when there is an upper half.
  if (CounterWidth > 32) begin : g_wide
    assign cnt_lo_wr = {cnt_q[CounterWidth-1:32], wdata_i};
    assign cnt_hi_wr = {wdata_i[CounterWidth-33:0], cnt_q[31:0]};
    assign hi_en     = we_hi_i;
  end else begin : g_narrow
    assign cnt_lo_wr = wdata_i;
    assign cnt_hi_wr = cnt_q;
    assign hi_en     = 1'b0;
  end

  // The extra top bit is the carry out, i.e. the wrap indication.
  assign cnt_inc = {1'b0, cnt_q} + {{CounterWidth{1'b0}}, 1'b1};

  always_comb begin
    cnt_d = cnt_q;
    ovf_d = 1'b0;
    if (we_lo_i) begin
      cnt_d = cnt_lo_wr;
    end else if (hi_en) begin
      cnt_d = cnt_hi_wr;
    end else if (inc_i) begin
      cnt_d = cnt_inc[CounterWidth-1:0];
      ovf_d = cnt_inc[CounterWidth];
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
      ovf_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      ovf_q <= ovf_d;
    end
  end

  assign value_o = cnt_q;
  assign ovf_o   = ovf_q;

endmodule

// File: rtl/ibex_hpm_counter_bank.sv
// ----------------------------------------------------------------------------
// ibex_hpm_counter_bank
// Bank of RISC-V hardware performance monitors mhpmcounter3..3+N-1 (with high
// halves), their mhpmevent selectors and mcountinhibit[31:3]. Sits beside the
// CSR file, which muxes csr_rdata_o in whenever csr_hit_o is set.
// Ports:
//   clk_i, rst_ni   clock, asynchronous active-low reset
//   csr_access_i    CSR instruction valid this cycle
//   csr_we_i        write strobe (qualified by csr_access_i)
//   csr_addr_i      CSR number
//   csr_wdata_i     write data, set/clear already resolved
//   csr_rdata_o     combinational read data, 0 when not hit
//   csr_hit_o       address lies in one of the HPM ranges (indices 3..31)
//   event_i         one-cycle event pulses
//   stopcount_i     freeze all counting (debug stopcount)
//   ovf_o           per-counter one-cycle wrap pulse
// Indices at or above 3+N hit but read as zero and ignore writes.
// ----------------------------------------------------------------------------
module ibex_hpm_counter_bank
  import ibex_hpm_counter_bank_pkg::*;
#(
  parameter int unsigned MHPMCounterNum   = 10,
  parameter int unsigned MHPMCounterWidth = 40,
  parameter int unsigned NumEvents        = 16
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 csr_access_i,
  input  logic                 csr_we_i,
  input  logic [11:0]          csr_addr_i,
  input  logic [31:0]          csr_wdata_i,
  output logic [31:0]          csr_rdata_o,
  output logic                 csr_hit_o,
  input  logic [NumEvents-1:0] event_i,
  input  logic                 stopcount_i,
  output logic [((MHPMCounterNum > 0) ? MHPMCounterNum : 1)-1:0] ovf_o
);

  localparam int unsigned N  = MHPMCounterNum;
  // Storage is sized at least 1 so a zero-counter build still elaborates.
  localparam int unsigned NC = (N > 0) ? N : 1;

  // --------------------------------------------------------------------------
  // Address decode
  // --------------------------------------------------------------------------
  hpm_space_e  space;
  logic [4:0]  idx;
  logic [4:0]  ctr_sel;
  logic        idx_valid;
  logic        is_inhibit;
  logic        csr_wr;

  assign space      = hpm_space(csr_addr_i);
  assign idx        = csr_addr_i[4:0];
  assign idx_valid  = (idx >= 5'(MHPM_FIRST_IDX));
  // Only meaningful when idx_valid; wraps for indices 0..2.
  assign ctr_sel    = idx - 5'(MHPM_FIRST_IDX);
  assign is_inhibit = (csr_addr_i == CSR_MCOUNTINHIBIT);
  assign csr_wr     = csr_access_i & csr_we_i;

  assign csr_hit_o  = is_inhibit | ((space != HPM_SPACE_NONE) & idx_valid);

  // --------------------------------------------------------------------------
  // Per-counter state and control
  // --------------------------------------------------------------------------
  logic [NumEvents-1:0] mhpmevent_q [NC];
  logic [NC-1:0]        inhibit_q;
  logic [NC-1:0]        ev_we;
  logic [NC-1:0]        cnt_we_lo;
  logic [NC-1:0]        cnt_we_hi;
  logic [NC-1:0]        cnt_inc;
  logic [NC-1:0]        cnt_ovf;
  logic [31:0]          cnt_lo [NC];
  logic [31:0]          cnt_hi [NC];

  for (genvar gi = 0; gi < NC; gi++) begin : g_ctr
    if (gi < N) begin : g_impl
      logic                        sel;
      logic [MHPMCounterWidth-1:0] value;

      assign sel           = csr_wr & idx_valid & (ctr_sel == 5'(gi));
      assign ev_we[gi]     = sel & (space == HPM_SPACE_EVENT);
      assign cnt_we_lo[gi] = sel & (space == HPM_SPACE_CNT_LO);
      assign cnt_we_hi[gi] = sel & (space == HPM_SPACE_CNT_HI);

      // Registered mask and inhibit are used, so a same-cycle write to
      // either only affects counting from the following cycle.
      assign cnt_inc[gi] = (|(mhpmevent_q[gi] & event_i)) & ~inhibit_q[gi] & ~stopcount_i;

      ibex_hpm_counter #(
        .CounterWidth (MHPMCounterWidth)
      ) u_counter (
        .clk_i    (clk_i),
        .rst_ni   (rst_ni),
        .inc_i    (cnt_inc[gi]),
        .we_lo_i  (cnt_we_lo[gi]),
        .we_hi_i  (cnt_we_hi[gi]),
        .wdata_i  (csr_wdata_i),
        .value_o  (value),
        .ovf_o    (cnt_ovf[gi])
      );

      assign cnt_lo[gi] = value[31:0];
      if (MHPMCounterWidth > 32) begin : g_hi
        assign cnt_hi[gi] = 32'(value[MHPMCounterWidth-1:32]);
      end else begin : g_no_hi
        assign cnt_hi[gi] = 32'h0;
      end
    end else begin : g_none
      assign ev_we[gi]     = 1'b0;
      assign cnt_we_lo[gi] = 1'b0;
      assign cnt_we_hi[gi] = 1'b0;
      assign cnt_inc[gi]   = 1'b0;
      assign cnt_ovf[gi]   = 1'b0;
      assign cnt_lo[gi]    = 32'h0;
      assign cnt_hi[gi]    = 32'h0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int k = 0; k < NC; k++) begin
        mhpmevent_q[k] <= '0;
      end
    end else begin
      for (int k = 0; k < NC; k++) begin
        if (ev_we[k]) begin
          mhpmevent_q[k] <= csr_wdata_i[NumEvents-1:0];
        end
      end
    end
  end

  // mcountinhibit bit 3+k controls counter k; lower bits belong to the CSR file.
  if (N > 0) begin : g_inhibit
    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        inhibit_q <= '0;
      end else if (csr_wr & is_inhibit) begin
        inhibit_q <= csr_wdata_i[MHPM_FIRST_IDX +: NC];
      end
    end
  end else begin : g_no_inhibit
    assign inhibit_q = '0;
  end

  assign ovf_o = cnt_ovf;

  // --------------------------------------------------------------------------
  // Read mux
  // --------------------------------------------------------------------------
  logic [31:0] inhibit_word;

  always_comb begin
    inhibit_word = 32'h0;
    for (int k = 0; k < N; k++) begin
      inhibit_word[MHPM_FIRST_IDX + k] = inhibit_q[k];
    end
  end

  always_comb begin
    csr_rdata_o = 32'h0;
    if (is_inhibit) begin
      csr_rdata_o = inhibit_word;
    end else if (csr_hit_o) begin
      for (int k = 0; k < N; k++) begin
        if (ctr_sel == 5'(k)) begin
          case (space)
            HPM_SPACE_EVENT:  csr_rdata_o = 32'(mhpmevent_q[k]);
            HPM_SPACE_CNT_LO: csr_rdata_o = cnt_lo[k];
            HPM_SPACE_CNT_HI: csr_rdata_o = cnt_hi[k];
            default:          csr_rdata_o = 32'h0;
          endcase
        end
      end
    end
  end

endmodule

// File: tb/tb_ibex_hpm_counter_bank.sv
module tb_ibex_hpm_counter_bank;

  logic        clk;
  logic        rst_n;
  logic        csr_access;
  logic        csr_we;
  logic [11:0] csr_addr;
  logic [31:0] csr_wdata;
  logic [15:0] event_in;
  logic        stopcount;

  logic [31:0] rdata, rdata32;
  logic        hit, hit32;
  logic [9:0]  ovf, ovf32;

  logic        stop;          // stopcount level applied by every step
  int          checks = 0;
  int          errors = 0;
  logic [31:0] exp_q [$];     // scoreboard of expected read data

  ibex_hpm_counter_bank #(
    .MHPMCounterNum   (10),
    .MHPMCounterWidth (40),
    .NumEvents        (16)
  ) dut (
    .clk_i        (clk),
    .rst_ni       (rst_n),
    .csr_access_i (csr_access),
    .csr_we_i     (csr_we),
    .csr_addr_i   (csr_addr),
    .csr_wdata_i  (csr_wdata),
    .csr_rdata_o  (rdata),
    .csr_hit_o    (hit),
    .event_i      (event_in),
    .stopcount_i  (stopcount),
    .ovf_o        (ovf)
  );

  ibex_hpm_counter_bank #(
    .MHPMCounterNum   (10),
    .MHPMCounterWidth (32),
    .NumEvents        (16)
  ) dut32 (
    .clk_i        (clk),
    .rst_ni       (rst_n),
    .csr_access_i (csr_access),
    .csr_we_i     (csr_we),
    .csr_addr_i   (csr_addr),
    .csr_wdata_i  (csr_wdata),
    .csr_rdata_o  (rdata32),
    .csr_hit_o    (hit32),
    .event_i      (event_in),
    .stopcount_i  (stopcount),
    .ovf_o        (ovf32)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic wr(input logic [11:0] a, input logic [31:0] d, input logic [15:0] ev = 16'h0);
    @(negedge clk);
    csr_access = 1'b1; csr_we = 1'b1; csr_addr = a; csr_wdata = d;
    event_in = ev; stopcount = stop;
    $display("write addr=0x%03h data=0x%08h ev=0x%04h stop=%0b", a, d, ev, stop);
  endtask

  // Read: expected value pushed when the access is driven, popped when sampled.
  task automatic rd(input logic [11:0] a, input logic [31:0] e, input bit w32 = 1'b0,
                    input logic exp_hit = 1'b1);
    logic [31:0] got;
    logic        got_hit;
    @(negedge clk);
    csr_access = 1'b1; csr_we = 1'b0; csr_addr = a; csr_wdata = 32'h0;
    event_in = 16'h0; stopcount = stop;
    exp_q.push_back(e);
    #1;
    got     = w32 ? rdata32 : rdata;
    got_hit = w32 ? hit32 : hit;
    $display("read%s addr=0x%03h data=0x%08h hit=%0b", w32 ? "32" : "", a, got, got_hit);
    check($sformatf("rd%s_%03h", w32 ? "32" : "", a), got, exp_q.pop_front());
    check($sformatf("hit%s_%03h", w32 ? "32" : "", a), 32'(got_hit), 32'(exp_hit));
  endtask

  task automatic pulse(input logic [15:0] ev, input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      csr_access = 1'b0; csr_we = 1'b0; csr_addr = 12'h0; csr_wdata = 32'h0;
      event_in = ev; stopcount = stop;
    end
    $display("events ev=0x%04h cycles=%0d stop=%0b", ev, n, stop);
  endtask

  initial begin
    rst_n = 1'b0; stop = 1'b0;
    csr_access = 1'b0; csr_we = 1'b0; csr_addr = 12'h0; csr_wdata = 32'h0;
    event_in = 16'h0; stopcount = 1'b0;
    repeat (3) @(negedge clk);
    check("ovf_in_reset", 32'(ovf), 32'h0);
    rst_n = 1'b1;

    // Reset values
    rd(12'hB03, 32'h0);
    rd(12'hB83, 32'h0);
    rd(12'h323, 32'h0);
    rd(12'h320, 32'h0);
    check("ovf_after_reset", 32'(ovf), 32'h0);

    // Event mask selects bits 0 and 2; bit 1 is ignored, coincident events count once
    wr(12'h323, 32'h5);
    pulse(16'h0004, 7);
    pulse(16'h0002, 3);
    rd(12'hB03, 32'd7);
    pulse(16'h0005, 1);
    rd(12'hB03, 32'd8);
    rd(12'h323, 32'h5);
    wr(12'h324, 32'hFFFF_FFFF);
    rd(12'h324, 32'h0000_FFFF);

    // Wrap from 2^40-1
    wr(12'hB83, 32'hFF);
    wr(12'hB03, 32'hFFFF_FFFF);
    rd(12'hB03, 32'hFFFF_FFFF);
    rd(12'hB83, 32'hFF);
    check("ovf_before_wrap", 32'(ovf), 32'h0);
    pulse(16'h0001, 1);
    pulse(16'h0000, 1);
    #1;
    check("ovf_wrap_pulse", 32'(ovf), 32'h1);
    rd(12'hB03, 32'h0);
    check("ovf_one_cycle", 32'(ovf), 32'h0);
    rd(12'hB83, 32'h0);

    // Write wins over a same-cycle increment; high half held
    wr(12'hB83, 32'h12);
    wr(12'hB03, 32'h10, 16'h0004);
    rd(12'hB03, 32'h10);
    rd(12'hB83, 32'h12);

    // Old mask gates the cycle in which the mask is rewritten
    wr(12'h323, 32'h0, 16'h0004);
    pulse(16'h0004, 1);
    rd(12'hB03, 32'h11);
    wr(12'h323, 32'h5);

    // mcountinhibit
    wr(12'h320, 32'h8);
    rd(12'h320, 32'h8);
    wr(12'h320, 32'hFFFF_FFFF);
    rd(12'h320, 32'h0000_1FF8);
    pulse(16'h0004, 20);
    rd(12'hB03, 32'h11);
    wr(12'h320, 32'h0);
    rd(12'h320, 32'h0);
    pulse(16'h0004, 1);
    rd(12'hB03, 32'h12);

    // stopcount freezes counting but CSR writes still land
    stop = 1'b1;
    pulse(16'h0004, 20);
    rd(12'hB03, 32'h12);
    wr(12'hB03, 32'h40, 16'h0004);
    pulse(16'h0004, 3);
    rd(12'hB03, 32'h40);
    stop = 1'b0;
    pulse(16'h0004, 1);
    rd(12'hB03, 32'h41);

    // Last implemented index vs. unimplemented indices
    wr(12'hB0C, 32'hABC);
    rd(12'hB0C, 32'hABC);
    wr(12'hB0D, 32'h123);
    rd(12'hB0D, 32'h0);
    wr(12'h32C, 32'hF);
    rd(12'h32C, 32'hF);
    wr(12'h32D, 32'hF);
    rd(12'h32D, 32'h0);
    wr(12'hB1F, 32'hDEAD);
    rd(12'hB1F, 32'h0);
    rd(12'h321, 32'h0, 1'b0, 1'b0);
    rd(12'hB02, 32'h0, 1'b0, 1'b0);
    rd(12'h300, 32'h0, 1'b0, 1'b0);

    // 32-bit counters: high half hardwired to zero
    wr(12'hB83, 32'h1);
    rd(12'hB83, 32'h1);
    rd(12'hB83, 32'h0, 1'b1);

    // Asynchronous reset in mid-count
    wr(12'hB03, 32'h55);
    rd(12'hB03, 32'h55);
    @(negedge clk);
    csr_access = 1'b1; csr_we = 1'b0; csr_addr = 12'hB03; event_in = 16'h0004;
    exp_q.push_back(32'h0);
    #2 rst_n = 1'b0;
    #1;
    $display("async reset read addr=0xb03 data=0x%08h", rdata);
    check("rd_async_reset", rdata, exp_q.pop_front());
    check("ovf_async_reset", 32'(ovf), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    rd(12'hB03, 32'h0);
    rd(12'h323, 32'h0);
    rd(12'h320, 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
